spi_byte_read: RTL



---
 rtl/spi_flash_pkg.sv | 23 ++
 rtl/spi_sck_gen.sv | 53 +++++
 rtl/spi_byte_read.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash access blocks (page-program writer,
// byte reader).
//   - flash instruction opcodes
//   - reader FSM state encoding
//   - default SPI bit period in sclk cycles
package spi_flash_pkg;

    localparam logic [7:0] WREN = 8'h06;
    localparam logic [7:0] PP   = 8'h02;
    localparam logic [7:0] READ = 8'h03;

    localparam int DEFAULT_CLK_DIV = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LEAD      = 3'd1,
        ST_SHIFT_OUT = 3'd2,
        ST_SHIFT_IN  = 3'd3,
        ST_TAIL      = 3'd4,
        ST_GAP       = 3'd5
    } rd_state_t;

endpackage

// File: rtl/spi_sck_gen.sv
// SPI mode-0 bit-period generator.
// A phase counter runs 0..CLK_DIV-1 while cnt_en is high and is held at 0
// otherwise. sck is registered: low for the first half of the period, high
// for the second half, and only while sck_en is high.
// Ports:
//   sclk, rst_n   system clock, async active-low reset
//   cnt_en        run the phase counter (any state that spends bit periods)
//   sck_en        allow sck to toggle (shift states only)
//   sck           SPI clock
//   shift_stb     last phase of a bit period; registers updated on it take
//                 their new value at phase 0 of the next period
//   sample_stb    last high cycle of sck; MISO is captured here
module spi_sck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic sclk,
    input  logic rst_n,
    input  logic cnt_en,
    input  logic sck_en,
    output logic sck,
    output logic shift_stb,
    output logic sample_stb
);

    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);
    // sck register is loaded one cycle early so it is high from CLK_DIV/2
    localparam logic [PW-1:0] PH_RISE = PW'(CLK_DIV / 2 - 1);

    logic [PW-1:0] phase;

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (!cnt_en || phase == PH_LAST) begin
            phase <= '0;
        end else begin
            phase <= phase + 1'b1;
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            sck <= 1'b0;
        end else begin
            sck <= sck_en && (phase >= PH_RISE) && (phase != PH_LAST);
        end
    end

    assign shift_stb  = cnt_en && (phase == PH_LAST);
    assign sample_stb = sck_en && (phase == PH_LAST);

endmodule

// File: rtl/spi_byte_read.sv
// SPI flash byte reader (mode 0 master).
// Issues READ_INST plus a 24-bit address, then clocks in rd_len bytes and
// presents each one as a single-cycle rd_valid strobe. Never stalls: the
// consumer takes one byte per 8*CLK_DIV cycles.
// Ports:
//   sclk, rst_n        system clock, async active-low reset
//   rd_start           start request, accepted only in IDLE with rd_len != 0
//   rd_addr, rd_len    start address and byte count (1..256), latched on accept
//   sdo                flash MISO
//   cs_n, sck, sdi     flash chip select, clock, MOSI
//   rd_data, rd_valid  received byte and its strobe
//   busy, done         transaction in progress / end-of-transaction pulse
//
// state        | meaning
// IDLE         | waiting for rd_start
// LEAD         | cs_n low, one bit period of CS setup, sck held low
// SHIFT_OUT    | 32 bits out: instruction then address, MSB first
// SHIFT_IN     | 8*rd_len bits in from sdo, byte strobes
// TAIL         | one cycle, cs_n has just risen
// GAP          | cs_n high for CS_HIGH cycles, done on the last one
module spi_byte_read
    import spi_flash_pkg::*;
#(
    parameter int         CLK_DIV   = DEFAULT_CLK_DIV,
    parameter int         CS_HIGH   = 8,
    parameter logic [7:0] READ_INST = READ
) (
    input  logic        sclk,
    input  logic        rst_n,
    input  logic        rd_start,
    input  logic [23:0] rd_addr,
    input  logic [8:0]  rd_len,
    input  logic        sdo,
    output logic        cs_n,
    output logic        sck,
    output logic        sdi,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        busy,
    output logic        done
);

    localparam int GW = $clog2(CS_HIGH + 1);

    rd_state_t     state, state_nxt;
    logic          accept;
    logic          shift_stb, sample_stb;
    logic          cnt_en, sck_en;
    logic [4:0]    bit_cnt;
    logic [8:0]    byte_cnt;
    logic [GW-1:0] gap_cnt;
    // bit 7 of the instruction goes straight to sdi, so only 31 bits remain
    logic [30:0]   sr_out;
    logic [6:0]    sr_in;

    assign cnt_en = (state == ST_LEAD) || (state == ST_SHIFT_OUT) || (state == ST_SHIFT_IN);
    assign sck_en = (state == ST_SHIFT_OUT) || (state == ST_SHIFT_IN);

    spi_sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .sclk       (sclk),
        .rst_n      (rst_n),
        .cnt_en     (cnt_en),
        .sck_en     (sck_en),
        .sck        (sck),
        .shift_stb  (shift_stb),
        .sample_stb (sample_stb)
    );

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rd_start && rd_len != '0) begin
                    accept    = 1'b1;
                    state_nxt = ST_LEAD;
                end
            end
            ST_LEAD: begin
                if (shift_stb) state_nxt = ST_SHIFT_OUT;
            end
            ST_SHIFT_OUT: begin
                if (shift_stb && bit_cnt == '0) state_nxt = ST_SHIFT_IN;
            end
            ST_SHIFT_IN: begin
                if (shift_stb && bit_cnt == '0 && byte_cnt == 9'd1) state_nxt = ST_TAIL;
            end
            ST_TAIL: begin
                state_nxt = ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt == '0) begin
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            cs_n     <= 1'b1;
            busy     <= 1'b0;
            sdi      <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            gap_cnt  <= '0;
            sr_out   <= '0;
            sr_in    <= '0;
        end else begin
            rd_valid <= 1'b0;
            cs_n     <= !((state_nxt == ST_LEAD) || (state_nxt == ST_SHIFT_OUT) ||
                          (state_nxt == ST_SHIFT_IN));
            busy     <= (state_nxt != ST_IDLE);

            if (accept) begin
                sr_out   <= {READ_INST[6:0], rd_addr};
                sdi      <= READ_INST[7];
                byte_cnt <= rd_len;
                bit_cnt  <= 5'd31;
            end

            case (state)
                ST_SHIFT_OUT: begin
                    if (shift_stb) begin
                        sr_out <= {sr_out[29:0], 1'b0};
                        if (bit_cnt == '0) begin
                            sdi     <= 1'b0;
                            bit_cnt <= 5'd7;
                        end else begin
                            sdi     <= sr_out[30];
                            bit_cnt <= bit_cnt - 5'd1;
                        end
                    end
                end
                ST_SHIFT_IN: begin
                    if (sample_stb) begin
                        sr_in <= {sr_in[5:0], sdo};
                    end
                    if (shift_stb) begin
                        if (bit_cnt == '0) begin
                            rd_data  <= {sr_in, sdo};
                            rd_valid <= 1'b1;
                            byte_cnt <= byte_cnt - 9'd1;
                            bit_cnt  <= 5'd7;
                        end else begin
                            bit_cnt  <= bit_cnt - 5'd1;
                        end
                    end
                end
                ST_TAIL: begin
                    gap_cnt <= GW'(CS_HIGH - 1);
                end
                ST_GAP: begin
                    if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
